matmul_scheduler: RTL



---
 rtl/matmul_pkg.sv | 24 ++
 rtl/matmul_wr_delay.sv | 36 +++
 rtl/matmul_scheduler.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// matmul_pkg: shared types and constants for the matrix-multiply sequencer.
//   state_t     : scheduler FSM states
//   N_DEF       : default matrix dimension
//   MAC_LAT_DEF : default MAC pipeline latency
//   width_of()  : index/address width helper (never returns less than 1)
package matmul_pkg;

    localparam int unsigned N_DEF       = 10;
    localparam int unsigned MAC_LAT_DEF = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Bits needed to count 0..n-1; a 1-value range still gets one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/matmul_wr_delay.sv
// matmul_wr_delay: DEPTH-stage {valid, addr} shift register that lines the
// issue address up with the MAC result it belongs to.
//   clk, rst (async, active-high) : clock / clear of every stage
//   in_valid, in_addr             : operand issue and its result address
//   out_valid, out_addr           : write strobe and address, DEPTH cycles later
module matmul_wr_delay #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr
);

    logic [ADDR_W:0] pipe [DEPTH];

    // Address is zeroed when not valid so idle stages never show a stale address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {in_valid, in_valid ? in_addr : ADDR_W'(0)};
            for (int i = 1; i < int'(DEPTH); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign {out_valid, out_addr} = pipe[DEPTH-1];

endmodule

// File: rtl/matmul_scheduler.sv
// matmul_scheduler: sequencer for the N x N matrix-multiply datapath.
// Pulses the operand load strobe, walks (row, col) in row-major order one
// dot product per cycle, delays the issue address by MAC_LAT cycles for the
// result write, and pulses done after the last write.
//   clk, rst (async, active-high)
//   start    : request a run (sampled only in IDLE)
//   hold     : operand-fetch back-pressure, freezes issue
//   busy     : high outside IDLE
//   done     : one-cycle completion pulse
//   load     : one-cycle operand load strobe
//   op_valid : operands for (row_idx, col_idx) issued this cycle
//   row_idx, col_idx : current issue position
//   wr_en, wr_addr   : result write strobe and address (row*N+col)
//   perf_cycles      : busy-cycle counter, present only when the
//                      MATMUL_SCHED_PERF_EN macro is defined
module matmul_scheduler
    import matmul_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned MAC_LAT = MAC_LAT_DEF,
    parameter int unsigned IDX_W   = width_of(N),
    parameter int unsigned ADDR_W  = width_of(N * N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              load,
    output logic              op_valid,
    output logic [IDX_W-1:0]  row_idx,
    output logic [IDX_W-1:0]  col_idx,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
`ifdef MATMUL_SCHED_PERF_EN
    ,
    output logic [15:0]       perf_cycles
`endif
);

    localparam int unsigned LAT_W = width_of(MAC_LAT);

    state_t            state;
    logic [LAT_W-1:0]  drain_cnt;
    logic [ADDR_W-1:0] issue_addr;

    // Issue is the only output that follows hold within the same cycle.
    assign op_valid   = (state == ISSUE) && !hold;
    assign issue_addr = ADDR_W'(row_idx) * ADDR_W'(N) + ADDR_W'(col_idx);

    // Scheduler FSM with registered strobes and index counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            load      <= 1'b0;
            done      <= 1'b0;
            row_idx   <= '0;
            col_idx   <= '0;
            drain_cnt <= '0;
        end else begin
            load <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= LOAD;
                        load    <= 1'b1;
                        busy    <= 1'b1;
                        row_idx <= '0;
                        col_idx <= '0;
                    end
                end
                LOAD: begin
                    state <= ISSUE;
                end
                ISSUE: begin
                    if (!hold) begin
                        if (col_idx == IDX_W'(N - 1)) begin
                            if (row_idx == IDX_W'(N - 1)) begin
                                // Last operand pair issued; indices park at N-1.
                                state     <= DRAIN;
                                drain_cnt <= LAT_W'(MAC_LAT - 1);
                            end else begin
                                col_idx <= '0;
                                row_idx <= row_idx + 1'b1;
                            end
                        end else begin
                            col_idx <= col_idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // Wait out the MAC pipeline so the last write lands first.
                    if (drain_cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Result write address delay line.
    matmul_wr_delay #(
        .DEPTH  (MAC_LAT),
        .ADDR_W (ADDR_W)
    ) u_wr_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (op_valid),
        .in_addr   (issue_addr),
        .out_valid (wr_en),
        .out_addr  (wr_addr)
    );

`ifdef MATMUL_SCHED_PERF_EN
    // Busy-cycle counter: cleared on accepted start, saturating, held in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (state == IDLE && start) begin
            perf_cycles <= '0;
        end else if (busy && perf_cycles != 16'hFFFF) begin
            perf_cycles <= perf_cycles + 16'd1;
        end
    end
`endif

endmodule
